// File: rtl/ram_stream_reader.sv
// ram_stream_reader: streams an inclusive RAM address range, one byte at a time, to a UART transmitter.
module ram_stream_reader #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_q,
  output logic              tx_dv,
  output logic [DATA_W-1:0] tx_byte,
  input  logic              tx_done,
  output logic              busy,
  output logic              fin,
  output logic [ADDR_W:0]   byte_count
);
  typedef enum logic [2:0] {IDLE, FETCH, WAIT_RD, SEND, WAIT_TX, DONE} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, end_q, end_d;
  logic [DATA_W-1:0] byte_q, byte_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              fin_q, fin_d;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      end_q   <= '0;
      byte_q  <= '0;
      cnt_q   <= '0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      end_q   <= end_d;
      byte_q  <= byte_d;
      cnt_q   <= cnt_d;
      fin_q   <= fin_d;
    end
  end
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    end_d   = end_q;
    byte_d  = byte_q;
    cnt_d   = cnt_q;
    fin_d   = fin_q;
    if (state_q != IDLE && abort) begin
      state_d = IDLE;
      fin_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          addr_d  = start_addr;
          end_d   = end_addr;
          cnt_d   = '0;
          fin_d   = start_addr > end_addr;
          state_d = start_addr > end_addr ? DONE : FETCH;
        end
        FETCH:   state_d = WAIT_RD;
        WAIT_RD: begin
          byte_d  = ram_q;
          state_d = SEND;
        end
        SEND:    state_d = WAIT_TX;
        // Compare before incrementing so a range ending at the top address never wraps.
        WAIT_TX: if (tx_done) begin
          cnt_d   = cnt_q + 1'b1;
          fin_d   = addr_q == end_q;
          addr_d  = addr_q == end_q ? addr_q : addr_q + 1'b1;
          state_d = addr_q == end_q ? DONE : FETCH;
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end
  assign ram_addr   = addr_q;
  assign tx_dv      = state_q == SEND;
  assign tx_byte    = byte_q;
  assign busy       = state_q inside {FETCH, WAIT_RD, SEND, WAIT_TX};
  assign fin        = fin_q;
  assign byte_count = cnt_q;
endmodule

// File: tb/tb_ram_stream_reader.sv
// tb_ram_stream_reader: scoreboard bench for ram_stream_reader with a RAM model and a UART responder.
module tb_ram_stream_reader;
  logic        clk = 1'b0, reset_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic [17:0] start_addr = '0, end_addr = '0, ram_addr;
  logic [7:0]  ram_q = '0, tx_byte;
  logic        tx_dv, tx_done, busy, fin;
  logic [18:0] byte_count;
  logic        auto_en = 1'b0, auto_done = 1'b0, man_done = 1'b0, fresh = 1'b0;
  logic        watch = 1'b0, saw_zero = 1'b0;
  int          cyc = 0, ref_cyc = 0, total = 0, bad = 0;
  logic [7:0]  exp_q[$];

  ram_stream_reader dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .start_addr(start_addr), .end_addr(end_addr), .ram_addr(ram_addr),
    .ram_q(ram_q), .tx_dv(tx_dv), .tx_byte(tx_byte), .tx_done(tx_done),
    .busy(busy), .fin(fin), .byte_count(byte_count)
  );

  assign tx_done = auto_done | man_done;

  initial forever #5 clk = ~clk;

  function automatic logic [7:0] mem(input logic [17:0] a);
    return a == 18'd5 ? 8'h11 : a == 18'd6 ? 8'h22 : a == 18'd7 ? 8'h33 : a[7:0] ^ 8'hA5;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    ram_q <= mem(ram_addr);
    if (tx_done || (start && fresh)) ref_cyc <= cyc;
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (watch && ram_addr == 18'd0) saw_zero <= 1'b1;
    if (reset_n && tx_dv) begin
      if (exp_q.size() == 0) chk("extra_dv", 32'd1, 32'd0);
      else begin
        chk("byte", {24'd0, tx_byte}, {24'd0, exp_q.pop_front()});
        chk("latency", cyc - ref_cyc, 32'd3);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (auto_en && tx_dv) begin
      repeat (10) @(negedge clk);
      auto_done = 1'b1;
      @(negedge clk);
      auto_done = 1'b0;
    end
  end

  task automatic go(input logic [17:0] a, input logic [17:0] e);
    start_addr = a;
    end_addr   = e;
    start      = 1'b1;
    fresh      = 1'b1;
    for (int x = int'(a); x <= int'(e); x++) exp_q.push_back(mem(x[17:0]));
    @(negedge clk);
    start = 1'b0;
    fresh = 1'b0;
  endtask

  task automatic wait_fin(input int max);
    for (int i = 0; i < max && !fin; i++) @(negedge clk);
    chk("fin_timeout", {31'd0, fin}, 32'd1);
  endtask

  task automatic wait_dv(input int max);
    for (int i = 0; i < max && !tx_dv; i++) @(negedge clk);
    chk("dv_timeout", {31'd0, tx_dv}, 32'd1);
  endtask

  task automatic pulse_done();
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
  endtask

  task automatic end_checks(input string tag, input int n);
    chk({tag, "_count"}, {13'd0, byte_count}, n);
    chk({tag, "_fin"}, {31'd0, fin}, 32'd1);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_q"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_addr", {14'd0, ram_addr}, 32'd0);
    chk("rst_dv", {31'd0, tx_dv}, 32'd0);
    chk("rst_byte", {24'd0, tx_byte}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_fin", {31'd0, fin}, 32'd0);
    chk("rst_count", {13'd0, byte_count}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    auto_en = 1'b1;
    go(18'd5, 18'd7);
    chk("busy_run", {31'd0, busy}, 32'd1);
    wait_fin(200);
    end_checks("basic", 3);

    @(negedge clk);
    go(18'd9, 18'd3);
    wait_fin(1);
    end_checks("empty", 0);
    repeat (4) @(negedge clk);

    go(18'h3FFFF, 18'h3FFFF);
    watch = 1'b1;
    wait_fin(100);
    watch = 1'b0;
    end_checks("top", 1);
    chk("top_nowrap", {31'd0, saw_zero}, 32'd0);
    chk("top_addr", {14'd0, ram_addr}, 32'h3FFFF);

    @(negedge clk);
    go(18'd5, 18'd7);
    wait_dv(10);
    @(negedge clk);
    start_addr = 18'd100;
    end_addr   = 18'd101;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_fin(200);
    end_checks("ignore", 3);

    auto_en = 1'b0;
    @(negedge clk);
    go(18'd5, 18'd8);
    wait_dv(10);
    repeat (2) @(negedge clk);
    pulse_done();
    wait_dv(10);
    @(negedge clk);
    man_done = 1'b1;
    abort    = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    abort    = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_fin", {31'd0, fin}, 32'd0);
    chk("abort_dv", {31'd0, tx_dv}, 32'd0);
    chk("abort_count", {13'd0, byte_count}, 32'd1);
    chk("abort_left", exp_q.size(), 32'd2);
    exp_q.delete();
    repeat (8) @(negedge clk);
    chk("abort_idle", {31'd0, busy}, 32'd0);

    go(18'd0, 18'd2);
    wait_dv(10);
    #1 reset_n = 1'b0;
    #1;
    chk("arst_dv", {31'd0, tx_dv}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_count", {13'd0, byte_count}, 32'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    chk("arst_hold_dv", {31'd0, tx_dv}, 32'd0);
    reset_n = 1'b1;
    auto_en = 1'b1;
    abort   = 1'b1;
    go(18'd0, 18'd2);
    abort = 1'b0;
    chk("start_abort_busy", {31'd0, busy}, 32'd1);
    wait_fin(200);
    end_checks("post_rst", 3);

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
